// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - memory-side fill/copy/compare sequencer for a single-port memory
module mem_dma #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] mismatch_offset,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RD, S_WR, S_CMP_A, S_CMP_B, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mismatch_q, mismatch_d;
  logic [ADDR_WIDTH-1:0] mm_off_q, mm_off_d;
  logic                  last_word;

  // The mode itself is not kept: the state entered at acceptance encodes it.
  assign last_word = (i_q == len_q - ADDR_WIDTH'(1));

  // State and operation registers; reset returns to IDLE at once so writes stop mid-cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      mismatch_q <= 1'b0;
      mm_off_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      mismatch_q <= mismatch_d;
      mm_off_q   <= mm_off_d;
    end
  end

  // Next-state: accept a request in IDLE, then walk the region one word (fill) or word pair at a time.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_d     = fill_q;
    data_d     = data_q;
    mismatch_d = mismatch_q;
    mm_off_d   = mm_off_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          len_d      = length;
          fill_d     = fill_data;
          mismatch_d = 1'b0;
          mm_off_d   = '0;
          i_d        = '0;
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            case (mode)
              2'b01:   state_d = S_RD;
              2'b10:   state_d = S_CMP_A;
              default: state_d = S_FILL;
            endcase
          end
        end
      end
      S_FILL: begin
        if (last_word) state_d = S_DONE;
        else           i_d = i_q + ADDR_WIDTH'(1);
      end
      S_RD: begin
        data_d  = mem_dout;
        state_d = S_WR;
      end
      S_WR: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_WIDTH'(1);
          state_d = S_RD;
        end
      end
      S_CMP_A: begin
        data_d  = mem_dout;
        state_d = S_CMP_B;
      end
      S_CMP_B: begin
        if (mem_dout != data_q) begin
          mismatch_d = 1'b1;
          mm_off_d   = i_q;
          state_d    = S_DONE;
        end else if (last_word) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_WIDTH'(1);
          state_d = S_CMP_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port and status decoded purely from registered state; idle states park the bus at zero.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state_q)
      S_FILL: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_q + i_q;
        mem_din   = fill_q;
      end
      S_RD, S_CMP_A: mem_addr = src_q + i_q;
      S_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_q + i_q;
        mem_din   = data_q;
      end
      S_CMP_B: mem_addr = dst_q + i_q;
      default: ;
    endcase
  end

  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign mismatch        = mismatch_q;
  assign mismatch_offset = mm_off_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - directed self-checking bench for mem_dma
module tb_mem_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [11:0] length = '0;
  logic [7:0]  fill_data = '0;
  logic        busy, done, mismatch, mem_wr_en;
  logic [11:0] mismatch_offset, mem_addr;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  mem [0:4095];
  logic        bd_clear = 1'b0;
  logic        bd_en = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  int          wr_count = 0;
  int          done_count = 0;

  int checks = 0;
  int errors = 0;

  mem_dma #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done), .mismatch(mismatch),
    .mismatch_offset(mismatch_offset), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  assign mem_dout = mem[mem_addr];

  // Behavioural memory with backdoor preload, write and done-pulse counters.
  always @(posedge clock) begin
    if (bd_clear) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'hEE;
    end else if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_din;
    end
    if (mem_wr_en) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clock);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clock); #1;
    bd_en = 1'b0;
  endtask

  // Starts an operation; lat is the cycle (1 = first after start edge) in which done is seen, -1 on timeout.
  task automatic run_op(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                        input logic [11:0] n, input logic [7:0] f,
                        output int lat, output logic busy_first, output logic mm, output logic [11:0] mo);
    @(negedge clock);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_data = f; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy_first = busy;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) lat = -1;
    mm = mismatch;
    mo = mismatch_offset;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (mismatch !== 1'b0 || mismatch_offset !== 12'h000) begin errors++; $display("FAIL reset_mismatch got %b/%h want 0/000", mismatch, mismatch_offset); end
    checks++; if (mem_wr_en !== 1'b0 || mem_addr !== 12'h000 || mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_bus got %b/%h/%h want 0/000/00", mem_wr_en, mem_addr, mem_din); end
    @(negedge clock); bd_clear = 1'b1;
    @(posedge clock); #1; bd_clear = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fill;
    int lat; logic bf, mm; logic [11:0] mo; int wc0;
    wc0 = wr_count;
    run_op(2'b00, 12'h000, 12'h010, 12'd4, 8'hA5, lat, bf, mm, mo);
    checks++; if (lat !== 5) begin errors++; $display("FAIL fill_latency got %0d want 5", lat); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL fill_busy got %b want 1", bf); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (mem[12'h010 + a] !== 8'hA5) begin errors++; $display("FAIL fill_word%0d got %h want a5", a, mem[12'h010 + a]); end
    end
    checks++; if (mem[12'h014] !== 8'hEE) begin errors++; $display("FAIL fill_untouched got %h want ee", mem[12'h014]); end
    checks++; if (wr_count - wc0 !== 4) begin errors++; $display("FAIL fill_writes got %0d want 4", wr_count - wc0); end
  endtask

  task automatic test_copy;
    int lat; logic bf, mm; logic [11:0] mo;
    logic [7:0] exp_v [3];
    exp_v = '{8'h11, 8'h22, 8'h33};
    for (int a = 0; a < 3; a++) poke(12'h100 + 12'(a), exp_v[a]);
    run_op(2'b01, 12'h100, 12'h200, 12'd3, 8'h00, lat, bf, mm, mo);
    checks++; if (lat !== 7) begin errors++; $display("FAIL copy_latency got %0d want 7", lat); end
    for (int a = 0; a < 3; a++) begin
      checks++; if (mem[12'h200 + a] !== exp_v[a]) begin errors++; $display("FAIL copy_dst%0d got %h want %h", a, mem[12'h200 + a], exp_v[a]); end
      checks++; if (mem[12'h100 + a] !== exp_v[a]) begin errors++; $display("FAIL copy_src%0d got %h want %h", a, mem[12'h100 + a], exp_v[a]); end
    end
    checks++; if (mem[12'h203] !== 8'hEE) begin errors++; $display("FAIL copy_untouched got %h want ee", mem[12'h203]); end
  endtask

  task automatic test_wrap;
    int lat; logic bf, mm; logic [11:0] mo;
    run_op(2'b00, 12'h000, 12'hFFE, 12'd4, 8'h5A, lat, bf, mm, mo);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency got %0d want 5", lat); end
    checks++; if (mem[12'hFFE] !== 8'h5A || mem[12'hFFF] !== 8'h5A) begin errors++; $display("FAIL wrap_top got %h %h want 5a 5a", mem[12'hFFE], mem[12'hFFF]); end
    checks++; if (mem[12'h000] !== 8'h5A || mem[12'h001] !== 8'h5A) begin errors++; $display("FAIL wrap_bottom got %h %h want 5a 5a", mem[12'h000], mem[12'h001]); end
    checks++; if (mem[12'h002] !== 8'hEE) begin errors++; $display("FAIL wrap_untouched got %h want ee", mem[12'h002]); end
  endtask

  task automatic test_compare;
    int lat; logic bf, mm; logic [11:0] mo;
    run_op(2'b10, 12'h100, 12'h200, 12'd3, 8'h00, lat, bf, mm, mo);
    checks++; if (lat !== 7) begin errors++; $display("FAIL cmp_eq_latency got %0d want 7", lat); end
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL cmp_eq_mismatch got %b want 0", mm); end
    poke(12'h201, 8'h00);
    run_op(2'b10, 12'h100, 12'h200, 12'd3, 8'h00, lat, bf, mm, mo);
    checks++; if (lat !== 5) begin errors++; $display("FAIL cmp_ne_latency got %0d want 5", lat); end
    checks++; if (mm !== 1'b1) begin errors++; $display("FAIL cmp_ne_mismatch got %b want 1", mm); end
    checks++; if (mo !== 12'h001) begin errors++; $display("FAIL cmp_ne_offset got %h want 001", mo); end
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL cmp_mismatch_held got %b want 1", mismatch); end
  endtask

  task automatic test_zero_length;
    int lat; logic bf, mm; logic [11:0] mo; int wc0;
    wc0 = wr_count;
    run_op(2'b00, 12'h000, 12'h700, 12'd0, 8'h33, lat, bf, mm, mo);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++; if (bf !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", bf); end
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL zero_mismatch_cleared got %b want 0", mm); end
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL zero_writes got %0d want %0d", wr_count, wc0); end
    checks++; if (mem[12'h700] !== 8'hEE) begin errors++; $display("FAIL zero_untouched got %h want ee", mem[12'h700]); end
  endtask

  task automatic test_reserved_mode;
    int lat; logic bf, mm; logic [11:0] mo;
    run_op(2'b11, 12'h100, 12'h500, 12'd2, 8'h77, lat, bf, mm, mo);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rsv_latency got %0d want 3", lat); end
    checks++; if (mem[12'h500] !== 8'h77 || mem[12'h501] !== 8'h77) begin errors++; $display("FAIL rsv_fill got %h %h want 77 77", mem[12'h500], mem[12'h501]); end
  endtask

  task automatic test_start_while_busy;
    int dc0;
    dc0 = done_count;
    @(negedge clock);
    mode = 2'b00; dst_addr = 12'h600; length = 12'd4; fill_data = 8'h99; start = 1'b1;
    @(posedge clock); #1;
    mode = 2'b00; dst_addr = 12'h300; length = 12'd1; fill_data = 8'h44;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checks++; if (done_count - dc0 !== 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", done_count - dc0); end
    checks++; if (mem[12'h300] !== 8'hEE) begin errors++; $display("FAIL busy_ignored got %h want ee", mem[12'h300]); end
    checks++; if (mem[12'h603] !== 8'h99) begin errors++; $display("FAIL busy_first_op got %h want 99", mem[12'h603]); end
  endtask

  task automatic test_reset_mid_copy;
    int dc0;
    for (int a = 0; a < 4; a++) poke(12'h180 + 12'(a), 8'h50 + 8'(a));
    dc0 = done_count;
    @(negedge clock);
    mode = 2'b01; src_addr = 12'h180; dst_addr = 12'h400; length = 12'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 12'h402) begin errors++; $display("FAIL rst_pre_write got %b/%h want 1/402", mem_wr_en, mem_addr); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", mem_wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checks++; if (done_count !== dc0) begin errors++; $display("FAIL rst_no_done got %0d want %0d", done_count, dc0); end
    checks++; if (mem[12'h401] !== 8'h51) begin errors++; $display("FAIL rst_word1 got %h want 51", mem[12'h401]); end
    checks++; if (mem[12'h402] !== 8'hEE || mem[12'h403] !== 8'hEE) begin errors++; $display("FAIL rst_words23 got %h %h want ee ee", mem[12'h402], mem[12'h403]); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_copy;
    test_wrap;
    test_compare;
    test_zero_length;
    test_reserved_mode;
    test_start_while_busy;
    test_reset_mid_copy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
